// File: rtl/miner_work_ctrl.sv
// miner_work_ctrl: work sequencing for the double-SHA-256 hasher pair.
// It drives the shared loop counter, issues one nonce per LOOP cycles and
// qualifies hash2 results. Golden nonces are queued in a small FIFO, which
// is drained into the serial transmitter under a busy handshake.
module miner_work_ctrl #(
    parameter int          LOOP_LOG2   = 5,
    parameter int          FIFO_LOG2   = 2,
    // Value loaded into issue_cnt by new work; nonzero only to reach the
    // end of the nonce range quickly in simulation.
    parameter logic [32:0] ISSUE_START = 33'd0
) (
    input  logic         hash_clk,
    input  logic         reset,
    input  logic [255:0] midstate_in,
    input  logic [255:0] data2_in,
    input  logic         work_valid,
    input  logic [31:0]  hash2_top,
    output logic [255:0] state_out,
    output logic [511:0] data_out,
    output logic [5:0]   cnt,
    output logic         feedback,
    output logic [31:0]  nonce_out,
    output logic [31:0]  tx_word,
    output logic         tx_send,
    input  logic         tx_busy,
    output logic         exhausted,
    output logic         fifo_overflow
);

    localparam int          LOOP     = 1 << LOOP_LOG2;
    localparam int          OFFSET   = (LOOP_LOG2 == 0) ? 131 :
                                       (LOOP_LOG2 == 1) ? 66  : (1 << (7 - LOOP_LOG2)) + 1;
    localparam logic [32:0] OFFSET33 = 33'(OFFSET);
    localparam logic [32:0] END_CNT  = 33'h1_0000_0000 + OFFSET33;
    localparam logic [5:0]  CNT_MASK = 6'(LOOP - 1);
    localparam int          DEPTH    = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0]   FCNT_ONE = 1;
    localparam logic [FIFO_LOG2:0]   FCNT_MAX = DEPTH;
    localparam logic [FIFO_LOG2-1:0] PTR_ONE  = 1;
    // SHA-256 padding for the 80-byte header: 0x80 marker and bit length 640.
    localparam logic [383:0] PAD     = {32'h0000_0280, 320'd0, 32'h8000_0000};

    typedef enum logic [1:0] {IDLE, RUN, DONE} work_state_t;
    typedef enum logic [1:0] {T_IDLE, T_HI, T_LO} tx_state_t;

    work_state_t work_state, work_nxt;
    tx_state_t   tx_state, tx_nxt;

    logic [5:0]  cnt_next;
    logic        fb_d1;
    logic        issue_slot, check_stb, run, at_end;
    logic [32:0] issue_cnt;
    logic [32:0] nonce_adj;
    logic [95:0] data_buf;
    logic        golden_r;
    logic [31:0] golden_nonce;

    logic [DEPTH-1:0][31:0] fifo_mem;
    logic [FIFO_LOG2-1:0]   wr_ptr, rd_ptr;
    logic [FIFO_LOG2:0]     fifo_cnt;
    logic                   fifo_empty, fifo_full, push, push_ok, pop;
    logic                   send_now;

    // Only the tail of the second data word reaches the hasher.
    logic data2_unused;
    assign data2_unused = ^data2_in[255:96];

    assign cnt_next   = (cnt + 6'd1) & CNT_MASK;
    assign issue_slot = (cnt_next == 6'd0);
    assign check_stb  = !fb_d1;
    assign run        = (work_state == RUN);
    assign at_end     = (issue_cnt == END_CNT);
    assign nonce_adj  = issue_cnt - OFFSET33;
    assign nonce_out  = issue_cnt[31:0];

    // Loop control free-runs in every state so the hashers never stall.
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            cnt      <= 6'd0;
            feedback <= 1'b0;
            fb_d1    <= 1'b0;
        end else begin
            cnt      <= cnt_next;
            feedback <= (cnt_next != 6'd0);
            fb_d1    <= feedback;
        end
    end

    // Work FSM state register.
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) work_state <= IDLE;
        else       work_state <= work_nxt;
    end

    // Work FSM next state: new work always restarts, range end drains to DONE.
    always_comb begin
        work_nxt = work_state;
        if (work_valid)
            work_nxt = RUN;
        else if (run && at_end)
            work_nxt = DONE;
    end

    // Work latch, nonce issue and range-exhaustion flag.
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            state_out <= '0;
            data_buf  <= '0;
            data_out  <= '0;
            issue_cnt <= '0;
            exhausted <= 1'b0;
        end else begin
            if (work_valid) begin
                state_out <= midstate_in;
                data_buf  <= data2_in[95:0];
                issue_cnt <= ISSUE_START;
            end else if (run && !at_end && issue_slot) begin
                data_out  <= {PAD, issue_cnt[31:0], data_buf};
                issue_cnt <= issue_cnt + 33'd1;
            end
            if (work_valid)
                exhausted <= 1'b0;
            else if (run && at_end)
                exhausted <= 1'b1;
        end
    end

    // Golden check; the nonce is captured with the hit so a later issue
    // in the same slot cannot skew it. The first OFFSET results are stale.
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            golden_r     <= 1'b0;
            golden_nonce <= '0;
        end else begin
            golden_r <= run && check_stb && (hash2_top == 32'd0) && (issue_cnt >= OFFSET33);
            if (check_stb)
                golden_nonce <= nonce_adj[31:0];
        end
    end

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == FCNT_MAX);
    assign push       = golden_r;
    assign pop        = send_now;
    assign push_ok    = push && (!fifo_full || pop);

    // Golden-nonce FIFO; survives work reloads, lost only on reset.
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            fifo_mem <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= golden_nonce;
                wr_ptr           <= wr_ptr + PTR_ONE;
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (push_ok && !pop)
                fifo_cnt <= fifo_cnt + FCNT_ONE;
            else if (pop && !push_ok)
                fifo_cnt <= fifo_cnt - FCNT_ONE;
        end
    end

    // Sticky drop flag; a drop in the reload cycle still registers.
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset)
            fifo_overflow <= 1'b0;
        else if (push && !push_ok)
            fifo_overflow <= 1'b1;
        else if (work_valid)
            fifo_overflow <= 1'b0;
    end

    // TX FSM state register.
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) tx_state <= T_IDLE;
        else       tx_state <= tx_nxt;
    end

    // TX FSM: send when idle, then wait for a full busy rise/fall cycle.
    always_comb begin
        tx_nxt   = tx_state;
        send_now = 1'b0;
        case (tx_state)
            T_IDLE: if (!fifo_empty && !tx_busy) begin
                        send_now = 1'b1;
                        tx_nxt   = T_HI;
                    end
            T_HI:   if (tx_busy)  tx_nxt = T_LO;
            T_LO:   if (!tx_busy) tx_nxt = T_IDLE;
            default: tx_nxt = T_IDLE;
        endcase
    end

    // Registered strobe and word; the word holds until the next send.
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            tx_send <= 1'b0;
            tx_word <= '0;
        end else begin
            tx_send <= send_now;
            if (send_now)
                tx_word <= fifo_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_miner_work_ctrl.sv
// tb_miner_work_ctrl: scoreboard bench for miner_work_ctrl.
// dut runs LOOP_LOG2=5 against a reference model; dut0 runs LOOP_LOG2=0
// with a start count just below 2^32 to exercise range exhaustion.
module tb_miner_work_ctrl;

    localparam int          LOOP   = 32;
    localparam int          OFFSET = 5;
    localparam int          DEPTH  = 4;
    localparam logic [32:0] START0 = 33'h0_FFFF_FFF8;

    logic hash_clk = 1'b0;
    logic reset    = 1'b1;
    always #5 hash_clk = ~hash_clk;

    // dut (LOOP_LOG2=5)
    logic [255:0] midstate_in = '0, data2_in = '0;
    logic         work_valid = 1'b0;
    logic [31:0]  hash2_top  = 32'h1;
    logic         busy_hold = 1'b0, resp_busy = 1'b0;
    logic         tx_busy;
    logic [255:0] state_out;
    logic [511:0] data_out;
    logic [5:0]   cnt;
    logic         feedback, tx_send, exhausted, fifo_overflow;
    logic [31:0]  nonce_out, tx_word;
    assign tx_busy = busy_hold | resp_busy;

    // dut0 (LOOP_LOG2=0)
    logic [255:0] ms0 = 256'h5a5a, d20 = 256'h77;
    logic         wv0 = 1'b0, busy0 = 1'b0;
    logic [31:0]  h0 = 32'h1;
    logic [255:0] state_out0;
    logic [511:0] data_out0;
    logic [5:0]   cnt0;
    logic         feedback0, tx_send0, exhausted0, fifo_overflow0;
    logic [31:0]  nonce_out0, tx_word0;

    miner_work_ctrl #(.LOOP_LOG2(5), .FIFO_LOG2(2)) dut (
        .hash_clk(hash_clk), .reset(reset), .midstate_in(midstate_in), .data2_in(data2_in),
        .work_valid(work_valid), .hash2_top(hash2_top), .state_out(state_out),
        .data_out(data_out), .cnt(cnt), .feedback(feedback), .nonce_out(nonce_out),
        .tx_word(tx_word), .tx_send(tx_send), .tx_busy(tx_busy), .exhausted(exhausted),
        .fifo_overflow(fifo_overflow));

    miner_work_ctrl #(.LOOP_LOG2(0), .FIFO_LOG2(2), .ISSUE_START(START0)) dut0 (
        .hash_clk(hash_clk), .reset(reset), .midstate_in(ms0), .data2_in(d20),
        .work_valid(wv0), .hash2_top(h0), .state_out(state_out0),
        .data_out(data_out0), .cnt(cnt0), .feedback(feedback0), .nonce_out(nonce_out0),
        .tx_word(tx_word0), .tx_send(tx_send0), .tx_busy(busy0), .exhausted(exhausted0),
        .fifo_overflow(fifo_overflow0));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Reference model of loop control, issue counter and golden queue.
    logic [5:0]  m_cnt, m_cnt_nx;
    logic        m_fb, m_fbd1, m_run, m_ovf;
    logic [32:0] m_icnt;
    logic [32:0] m_adj;
    logic [31:0] exp_q[$];
    assign m_cnt_nx = (m_cnt + 6'd1) & 6'(LOOP - 1);
    assign m_adj    = m_icnt - 33'(OFFSET);

    always @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            m_cnt <= '0; m_fb <= 1'b0; m_fbd1 <= 1'b0;
            m_run <= 1'b0; m_icnt <= '0; m_ovf <= 1'b0;
            exp_q.delete();
        end else begin
            m_cnt  <= m_cnt_nx;
            m_fb   <= (m_cnt_nx != 6'd0);
            m_fbd1 <= m_fb;
            if (work_valid) begin
                m_icnt <= '0; m_run <= 1'b1; m_ovf <= 1'b0;
            end else if (m_run && m_cnt_nx == 6'd0) begin
                m_icnt <= m_icnt + 33'd1;
            end
            if (m_run && !m_fbd1 && hash2_top == 32'd0 && m_icnt >= 33'(OFFSET)) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(m_adj[31:0]);
                else m_ovf <= 1'b1;
            end
        end
    end

    // Send monitor and busy responder for dut.
    int   sends = 0, cyc = 0, last_send = 0, resp_cnt = 0;
    logic saw_busy = 1'b0;
    always @(negedge hash_clk) begin
        cyc++;
        if (reset) begin
            resp_cnt  = 0;
            resp_busy = 1'b0;
        end else begin
            if (tx_busy) saw_busy = 1'b1;
            if (tx_send === 1'b1) begin
                chk("sb_pending", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) chk("tx_word", tx_word, exp_q.pop_front());
                if (sends > 0) begin
                    chk("busy_handshake", saw_busy, 1'b1);
                    chk("send_gap", (cyc - last_send) >= 3, 1'b1);
                end
                sends++;
                last_send = cyc;
                saw_busy  = 1'b0;
                resp_cnt  = 2;
            end
            resp_busy = (resp_cnt > 0);
            if (resp_cnt > 0) resp_cnt--;
        end
    end

    // Drive hash2_top=0 on the check strobe where the model's issue_cnt==ic.
    task automatic golden_at(input logic [32:0] ic);
        int n = 0;
        while (!(m_run && !m_fbd1 && m_icnt == ic) && n < 20000) begin
            @(negedge hash_clk);
            n++;
        end
        chk("golden_wait", n < 20000, 1'b1);
        chk("cnt", cnt, m_cnt);
        chk("feedback", feedback, m_fb);
        hash2_top = 32'd0;
        @(negedge hash_clk);
        hash2_top = $urandom | 32'h1;
    endtask

    task automatic load_work(input logic [255:0] ms, input logic [255:0] d2);
        midstate_in = ms;
        data2_in    = d2;
        work_valid  = 1'b1;
        @(negedge hash_clk);
        work_valid  = 1'b0;
    endtask

    task automatic wait_sends(input int target, input int bound);
        int n = 0;
        while (sends < target && n < bound) begin
            @(negedge hash_clk);
            n++;
        end
        chk("send_count", sends, target);
    endtask

    task automatic check_zero_outs();
        chk("rst_state_out", state_out, '0);
        chk("rst_data_out", data_out, '0);
        chk("rst_cnt", cnt, '0);
        chk("rst_feedback", feedback, '0);
        chk("rst_nonce_out", nonce_out, '0);
        chk("rst_tx_word", tx_word, '0);
        chk("rst_tx_send", tx_send, '0);
        chk("rst_exhausted", exhausted, '0);
        chk("rst_fifo_overflow", fifo_overflow, '0);
    endtask

    initial begin
        logic [255:0] ms, d2;
        logic [511:0] exp_data;
        int k_send, k_exh, s0, n;
        logic dchk;

        // Reset state
        repeat (3) @(negedge hash_clk);
        check_zero_outs();
        chk("rst0_nonce", nonce_out0, '0);
        chk("rst0_exhausted", exhausted0, '0);
        chk("rst0_tx_send", tx_send0, '0);
        reset = 1'b0;
        repeat (2) @(negedge hash_clk);

        // Range exhaustion on dut0 (LOOP=1, OFFSET=131)
        wv0 = 1'b1;
        @(negedge hash_clk);
        wv0 = 1'b0;
        chk("d0_start", nonce_out0, 32'hFFFF_FFF8);
        chk("d0_state_out", state_out0, ms0);
        k_send = -1;
        k_exh  = -1;
        for (int k = 1; k <= 220 && k_exh < 0; k++) begin
            @(negedge hash_clk);
            h0 = (k == 108) ? 32'd0 : ($urandom | 32'h1);
            if (k == 5)   chk("d0_nonce5", nonce_out0, 32'hFFFF_FFFD);
            if (k == 139) chk("d0_not_exh_yet", exhausted0, 1'b0);
            if (tx_send0 && k_send < 0) begin
                k_send = k;
                chk("d0_tx_word", tx_word0, 32'hFFFF_FFE1);
            end
            busy0 = (k_send >= 0) && (k - k_send < 2);
            if (exhausted0 && k_exh < 0) k_exh = k;
        end
        chk("d0_send_seen_late", k_send >= 111, 1'b1);
        chk("d0_exh_cycle", k_exh, 140);
        chk("d0_end_nonce", nonce_out0, 32'd131);
        repeat (5) @(negedge hash_clk);
        chk("d0_frozen_nonce", nonce_out0, 32'd131);
        chk("d0_exh_sticky", exhausted0, 1'b1);
        wv0 = 1'b1;
        @(negedge hash_clk);
        wv0 = 1'b0;
        chk("d0_exh_clear", exhausted0, 1'b0);
        chk("d0_restart", nonce_out0, 32'hFFFF_FFF8);
        repeat (3) @(negedge hash_clk);
        chk("d0_rerun", nonce_out0, 32'hFFFF_FFFB);

        // First OFFSET checks are ignored; first data_out carries nonce 0
        ms = {8{32'hA5A5_0001}};
        d2 = {8{32'h1234_5678}};
        load_work(ms, d2);
        chk("state_out_T1", state_out, ms);
        chk("nonce_T1", nonce_out, 32'd0);
        exp_data = {32'h0000_0280, 320'd0, 32'h8000_0000, 32'd0, d2[95:0]};
        dchk = 1'b0;
        n = 0;
        while (m_icnt != 33'(OFFSET) && n < 1000) begin
            hash2_top = 32'd0;
            if (m_icnt == 33'd1 && !dchk) begin
                chk("data_out_nonce0", data_out, exp_data);
                dchk = 1'b1;
            end
            @(negedge hash_clk);
            n++;
        end
        hash2_top = 32'h1;
        chk("early_wait", n < 1000, 1'b1);
        repeat (8) @(negedge hash_clk);
        chk("no_early_send", sends, 0);

        // Single golden hit at issue_cnt 0x105
        golden_at(33'h105);
        wait_sends(1, 40);
        chk("tx_word_105", tx_word, 32'h100);

        // Busy held through 6 hits: 4 queued, overflow, then 4 ordered sends
        busy_hold = 1'b1;
        for (int i = 0; i < 6; i++) golden_at(33'h110 + 33'(i));
        repeat (4) @(negedge hash_clk);
        chk("ovf_set", fifo_overflow, 1'b1);
        chk("ovf_model", fifo_overflow, m_ovf);
        chk("no_send_busy", sends, 1);
        busy_hold = 1'b0;
        wait_sends(5, 100);
        repeat (20) @(negedge hash_clk);
        chk("exactly4", sends, 5);

        // Work reload mid-RUN keeps the queued nonce
        busy_hold = 1'b1;
        golden_at(33'h120);
        repeat (4) @(negedge hash_clk);
        ms = {8{32'hC0DE_0002}};
        d2 = {8{32'h0BAD_F00D}};
        load_work(ms, d2);
        chk("reload_state_out", state_out, ms);
        chk("reload_nonce", nonce_out, 32'd0);
        chk("reload_ovf_clr", fifo_overflow, 1'b0);
        busy_hold = 1'b0;
        wait_sends(6, 40);

        // Reset mid-RUN with two entries left and tx_send high
        busy_hold = 1'b1;
        golden_at(33'd6);
        golden_at(33'd7);
        golden_at(33'd8);
        repeat (4) @(negedge hash_clk);
        busy_hold = 1'b0;
        n = 0;
        while (tx_send !== 1'b1 && n < 40) begin
            @(negedge hash_clk);
            n++;
        end
        chk("pre_reset_send", tx_send, 1'b1);
        #2 reset = 1'b1;
        @(negedge hash_clk);
        check_zero_outs();
        reset = 1'b0;
        s0 = sends;
        repeat (150) @(negedge hash_clk);
        chk("no_send_after_reset", sends, s0);
        chk("idle_after_reset", nonce_out, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/miner_work_ctrl.md
# miner_work_ctrl

Sequencing controller for the double-SHA-256 mining datapath. It takes work from the serial receiver, drives the shared `cnt`/`feedback` loop control and the per-issue `state`/`data` words of both `sha256_transform` instances, and qualifies `hash2` results. It also detects nonce-range exhaustion and queues golden nonces in a small FIFO that is drained into the serial transmitter under a busy handshake. It sits between `serial_receive`/`serial_transmit` and the hasher pair inside `fpgaminer_top`.

## Interface
- `LOOP_LOG2`, 5: unroll setting, range 0..5; `LOOP` = 1<<LOOP_LOG2 cycles per issue slot.
- `FIFO_LOG2`, 2: golden-nonce FIFO depth = 1<<FIFO_LOG2.
- `hash_clk` in 1: the only clock.
- `reset` in 1: asynchronous, active-high.
- `midstate_in` in 256: midstate from the receiver.
- `data2_in` in 256: second data word from the receiver; bits [95:0] are used.
- `work_valid` in 1: single-cycle pulse; new work is on `midstate_in`/`data2_in`.
- `hash2_top` in 32: `hash2[255:224]` from the second hasher.
- `state_out` out 256: `rx_state` of the first hasher.
- `data_out` out 512: `rx_input` of the first hasher.
- `cnt` out 6: loop counter to both hashers.
- `feedback` out 1: feedback select to both hashers.
- `nonce_out` out 32: next nonce to issue, which is `issue_cnt[31:0]`.
- `tx_word` out 32: golden nonce presented to the transmitter.
- `tx_send` out 1: single-cycle send strobe.
- `tx_busy` in 1: transmitter busy.
- `exhausted` out 1: the full 2^32 range is checked for the current work.
- `fifo_overflow` out 1: sticky; a golden nonce was dropped.

## Operation
- Derived constant `OFFSET`: 131 if LOOP_LOG2=0, 66 if LOOP_LOG2=1, otherwise (1<<(7−LOOP_LOG2))+1.
- Loop control runs in every state.
  - `cnt` = (cnt+1)&(LOOP−1), or 0 when LOOP=1.
  - `feedback` <= (cnt_next≠0); it is always 0 when LOOP=1.
  - An issue slot is any cycle with cnt_next==0.
  - `fb_d1` is `feedback` delayed by one cycle. A check strobe is any cycle with `fb_d1`==0.
- Work FSM states are IDLE, RUN and DONE. Reset enters IDLE.
  - `work_valid` in any state latches `midstate_in` into `state_out` and `data2_in[95:0]` into the data buffer.
  - The same `work_valid` clears the 33-bit `issue_cnt`, `exhausted` and `fifo_overflow`, and moves the FSM to RUN.
  - In RUN, at each issue slot, `data_out` <= {384'h000002800…0080000000, issue_cnt[31:0], buf[95:0]}, then `issue_cnt`++.
  - At a RUN check strobe, `golden_r` <= (hash2_top==0) && (issue_cnt ≥ OFFSET).
  - When `golden_r` is set, the controller pushes (issue_cnt − OFFSET)[31:0] into the FIFO.
  - RUN→DONE when `issue_cnt` reaches 2^32+OFFSET. This drains the pipeline; issues beyond 2^32 carry don't-care nonces. `exhausted` is set on entry to DONE.
  - IDLE and DONE freeze `issue_cnt`, `data_out` and the checks. A pending `golden_r` still pushes.
- FIFO:
  - A push when full is dropped and sets `fifo_overflow`.
  - Simultaneous push and pop when full is accepted.
  - Work reload does not flush the FIFO.
- TX FSM states are T_IDLE, T_HI and T_LO.
  - T_IDLE: when the FIFO is non-empty and !tx_busy, `tx_word` <= head, pop, pulse `tx_send` for one cycle, go to T_HI.
  - T_HI: wait for tx_busy=1, then go to T_LO.
  - T_LO: wait for tx_busy=0, then go to T_IDLE.
  - `tx_word` holds stable until the next send.
- Reset mid-operation returns everything to reset values immediately; queued nonces are lost.

## Timing
- Reset values: `state_out`, `data_out`, `cnt`, `tx_word`, `nonce_out` = 0; `feedback`, `tx_send`, `exhausted`, `fifo_overflow` = 0; FIFO empty; FSMs in IDLE/T_IDLE.
- `work_valid` at cycle T: `state_out`, `issue_cnt`=0 and the FSM state are all updated at T+1. The first `data_out` carrying nonce 0 appears after the first issue slot at or after T+1.
- Golden path: check strobe at C sets `golden_r` at C+1, FIFO entry at C+2, and `tx_send` no earlier than C+3.
- The minimum spacing between `tx_send` pulses is 3 cycles.
- One nonce is issued per LOOP cycles.

## Test plan
- Reset held mid-RUN with 2 FIFO entries, `tx_send` high → all outputs 0 next edge, FIFO empty, no further `tx_send`.
- LOOP_LOG2=5, `work_valid`, `hash2_top` forced 0 only on the check strobe when `issue_cnt`=0x105 → one `tx_send`, `tx_word`=0x105−5=0x100.
- `hash2_top`=0 on the first OFFSET checks after new work → no push, no `tx_send`.
- FIFO_LOG2=2, `tx_busy` held 1, 6 golden events → 4 queued, `fifo_overflow`=1. Release busy → exactly 4 sends in push order, each waiting for a busy rise then fall.
- LOOP_LOG2=0, preload `issue_cnt` near 2^32 → `exhausted`=1 at `issue_cnt`=2^32+131, and checks continue until then. A later `work_valid` clears `exhausted` and returns to RUN.
- `work_valid` mid-RUN with 1 queued nonce → `issue_cnt` restarts at 0, the queued nonce is still transmitted, and `state_out` updates at T+1.
